// File: rtl/pim_peri_pkg.sv
// Shared types and constants for the PIM peripheral path.
// This package holds the controller state encoding and the fixed buffer interface widths.
package pim_peri_pkg;

    localparam int unsigned SH_W         = 20;
    localparam int unsigned RES_W        = 32;
    localparam int unsigned NUM_BITS_DEF = 8;
    localparam int unsigned IDX_W        = $clog2(NUM_BITS_DEF);

    // Bit-plane index width; at least one bit even for degenerate plane counts.
    function automatic int unsigned idx_width(input int unsigned num_bits);
        return (num_bits > 1) ? $clog2(num_bits) : 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DRAIN,
        READ,
        DONE
    } state_e;

endpackage

// File: rtl/pim_bit_shifter.sv
// Combinational left shift of an ADC sample by its bit-plane index.
// If SHIFT_SAT_EN is defined, an overflow saturates to all ones; otherwise the upper bits are truncated.
module pim_bit_shifter
    import pim_peri_pkg::*;
#(
    parameter int unsigned ADC_W = 12,
    parameter int unsigned CNT_W = 3
) (
    input  logic [ADC_W-1:0] data,
    input  logic [CNT_W-1:0] idx,
    output logic [SH_W-1:0]  shifted_c
);

    localparam int unsigned FULL_W = ADC_W + (2 ** CNT_W) - 1;

    logic [FULL_W-1:0] wide;

    assign wide = FULL_W'(data) << idx;

    if (FULL_W > SH_W) begin : g_ovf
        logic ovf;
        assign ovf = |wide[FULL_W-1:SH_W];
`ifdef SHIFT_SAT_EN
        assign shifted_c = ovf ? {SH_W{1'b1}} : wide[SH_W-1:0];
`else
        logic unused_ovf;
        assign unused_ovf = ovf;
        assign shifted_c  = wide[SH_W-1:0];
`endif
    end else begin : g_fit
        assign shifted_c = SH_W'(wide);
    end

endmodule

// File: rtl/pim_shift_ctrl.sv
// Bit-serial shift-and-accumulate controller in front of the PIM accumulation buffer.
// If SHIFT_SAT_EN is defined, shifted samples saturate instead of being truncated.
module pim_shift_ctrl
    import pim_peri_pkg::*;
#(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned ADC_W    = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    input  logic              adc_valid_i,
    output logic              adc_ready_o,
    input  logic [ADC_W-1:0]  adc_data_i,
    output logic              accum_buf_write_en_o,
    output logic [SH_W-1:0]   shifter_output_o,
    output logic              accum_buf_read_en_o,
    input  logic [RES_W-1:0]  accum_buf_output_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [RES_W-1:0]  result_o
);

    localparam int unsigned CNT_W = idx_width(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BITS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               accept;
    logic               wr_d;
    logic [SH_W-1:0]    sh_d;
    logic [SH_W-1:0]    shifted;
    logic [RES_W-1:0]   res_d;

    pim_bit_shifter #(
        .ADC_W (ADC_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .data      (adc_data_i),
        .idx       (idx_q),
        .shifted_c (shifted)
    );

    assign accept = (state_q == SHIFT) && adc_valid_i && adc_ready_o;

    // Next state, bit-plane index and next values of the write/result datapath.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = 1'b0;
        sh_d    = '0;
        res_d   = result_o;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    wr_d  = 1'b1;
                    sh_d  = shifted;
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: state_d = READ;
            READ: begin
                res_d   = accum_buf_output_i;
                state_d = DONE;
            end
            DONE: begin
                if (result_valid_o && result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status strobes are decoded from the next state so they align with the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q              <= IDLE;
            idx_q                <= '0;
            busy_o               <= 1'b0;
            adc_ready_o          <= 1'b0;
            accum_buf_write_en_o <= 1'b0;
            shifter_output_o     <= '0;
            accum_buf_read_en_o  <= 1'b0;
            result_valid_o       <= 1'b0;
            result_o             <= '0;
        end else begin
            state_q              <= state_d;
            idx_q                <= idx_d;
            busy_o               <= (state_d != IDLE);
            adc_ready_o          <= (state_d == SHIFT);
            accum_buf_write_en_o <= wr_d;
            shifter_output_o     <= sh_d;
            accum_buf_read_en_o  <= (state_d == READ);
            result_valid_o       <= (state_d == DONE);
            result_o             <= res_d;
        end
    end

endmodule

// File: tb/tb_pim_shift_ctrl.sv
// Randomized self-checking bench for pim_shift_ctrl with a behavioural accumulation buffer.
module tb_pim_shift_ctrl;

    localparam int unsigned NB  = 8;
    localparam int unsigned AW  = 12;
    localparam int unsigned AW2 = 14;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic           start, busy, adc_valid, adc_ready, wr_en, rd_en, res_valid, res_ready;
    logic [AW-1:0]  adc_data;
    logic [19:0]    sh_out;
    logic [31:0]    buf_out, res;

    logic           s_start, s_busy, s_valid, s_adc_ready, s_wr, s_rd, s_rv;
    logic [AW2-1:0] s_data;
    logic [19:0]    s_sh;
    logic [31:0]    s_res;

    pim_shift_ctrl #(.NUM_BITS(NB), .ADC_W(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start), .busy_o(busy),
        .adc_valid_i(adc_valid), .adc_ready_o(adc_ready), .adc_data_i(adc_data),
        .accum_buf_write_en_o(wr_en), .shifter_output_o(sh_out),
        .accum_buf_read_en_o(rd_en), .accum_buf_output_i(buf_out),
        .result_valid_o(res_valid), .result_ready_i(res_ready), .result_o(res)
    );

    pim_shift_ctrl #(.NUM_BITS(NB), .ADC_W(AW2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(s_start), .busy_o(s_busy),
        .adc_valid_i(s_valid), .adc_ready_o(s_adc_ready), .adc_data_i(s_data),
        .accum_buf_write_en_o(s_wr), .shifter_output_o(s_sh),
        .accum_buf_read_en_o(s_rd), .accum_buf_output_i(32'h0),
        .result_valid_o(s_rv), .result_ready_i(1'b1), .result_o(s_res)
    );

    // Accumulation buffer: adds on write, presents its sum during read, clears on read.
    logic [31:0] buf_sum;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     buf_sum <= 32'h0;
        else if (rd_en)  buf_sum <= 32'h0;
        else if (wr_en)  buf_sum <= buf_sum + 32'(sh_out);
    end
    assign buf_out = rd_en ? buf_sum : 32'h0;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int unsigned wq[$];
    int unsigned wcyc[$];
    int unsigned sq[$];
    int unsigned rd_cnt = 0, rd_cyc = 0, overlap = 0;
    always @(negedge clk_i) begin
        if (wr_en) begin wq.push_back(32'(sh_out)); wcyc.push_back(cyc); end
        if (rd_en) begin rd_cnt++; rd_cyc = cyc; end
        if (wr_en && rd_en) overlap++;
        if (s_wr) sq.push_back(32'(s_sh));
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: value * 2^idx, then saturate or truncate to 20 bits.
    function automatic logic [19:0] ref_shift(input logic [63:0] d, input int i);
        logic [63:0] f;
        f = d * (64'd1 << i);
        if (f > 64'hFFFFF) begin
`ifdef SHIFT_SAT_EN
            return 20'hFFFFF;
`else
            return f[19:0];
`endif
        end
        return f[19:0];
    endfunction

    logic [AW-1:0] d[NB];

    task automatic run_op(input string tag, input logic [AW-1:0] dv[NB], input int gap_max,
                          input int rdy_wait, input bit busy_start);
        logic [31:0] exp_sum;
        int s, n;
        exp_sum = 32'h0;
        for (int k = 0; k < int'(NB); k++) exp_sum += 32'(ref_shift(64'(dv[k]), k));
        wq.delete(); wcyc.delete(); rd_cnt = 0; overlap = 0;
        start = 1'b1; s = int'(cyc);
        @(negedge clk_i);
        start = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    adc_valid = 1'b0; adc_data = AW'($urandom);
                    @(negedge clk_i);
                end
            end
            adc_valid = 1'b1; adc_data = dv[i];
            if (busy_start && i == 3) start = 1'b1;
            n = 0;
            while (!adc_ready && n < 64) begin @(negedge clk_i); n++; end
            @(negedge clk_i);
            start = 1'b0;
        end
        adc_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 64) begin @(negedge clk_i); n++; end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        if (gap_max == 0) begin
            chk({tag, "_latency"}, 64'(int'(cyc) - s), 64'(NB + 3));
            chk({tag, "_rd_cycle"}, 64'(int'(rd_cyc) - s), 64'(NB + 2));
            if (wcyc.size() == NB)
                chk({tag, "_last_wr_cycle"}, 64'(int'(wcyc[NB-1]) - s), 64'(NB + 1));
        end
        repeat (rdy_wait) begin
            if (busy_start) start = 1'b1;
            chk({tag, "_hold"}, 64'(res), 64'(exp_sum));
            chk({tag, "_busy_done"}, 64'({busy, res_valid}), 64'd3);
            @(negedge clk_i);
        end
        start = 1'b0;
        res_ready = 1'b1;
        chk({tag, "_result"}, 64'(res), 64'(exp_sum));
        @(negedge clk_i);
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'({busy, res_valid}), 64'd0);
        chk({tag, "_res_keep"}, 64'(res), 64'(exp_sum));
        chk({tag, "_nwrites"}, 64'(wq.size()), 64'(NB));
        chk({tag, "_nreads"}, 64'(rd_cnt), 64'd1);
        chk({tag, "_overlap"}, 64'(overlap), 64'd0);
        for (int k = 0; k < int'(NB) && k < wq.size(); k++)
            chk($sformatf("%s_wr%0d", tag, k), 64'(wq[k]), 64'(ref_shift(64'(dv[k]), k)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0; adc_valid = 1'b0; adc_data = '0; res_ready = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_data = '0;
        #1;
        chk("rst_ctrl", 64'({busy, adc_ready, wr_en, rd_en, res_valid}), 64'd0);
        chk("rst_data", 64'({sh_out, res}), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int k = 0; k < int'(NB); k++) d[k] = AW'(1);
        run_op("ones", d, 0, 0, 1'b0);
        chk("ones_sum", 64'(res), 64'd255);

        for (int k = 0; k < int'(NB); k++) d[k] = AW'(12'hFFF);
        run_op("full", d, 0, 2, 1'b0);
        chk("full_sum", 64'(res), 64'h000FEF01);
        if (wq.size() == NB) chk("full_last", 64'(wq[NB-1]), 64'h7FF80);

        for (int k = 0; k < int'(NB); k++) d[k] = AW'($urandom);
        run_op("bp", d, 1, 5, 1'b0);

        for (int k = 0; k < int'(NB); k++) d[k] = AW'($urandom);
        run_op("busy_start", d, 0, 3, 1'b1);

        // Abort after three accepted planes.
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0; adc_valid = 1'b1; adc_data = AW'(1);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({busy, adc_ready, wr_en, rd_en, res_valid}), 64'd0);
        chk("midrst_data", 64'({sh_out, res}), 64'd0);
        adc_valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < int'(NB); k++) d[k] = AW'(1);
        run_op("after_rst", d, 0, 0, 1'b0);
        chk("after_rst_sum", 64'(res), 64'd255);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < int'(NB); k++) d[k] = AW'($urandom);
            run_op($sformatf("rand%0d", r), d, int'($urandom_range(2, 0)),
                   int'($urandom_range(5, 0)), 1'($urandom));
        end

        // Wide ADC: the top plane overflows the 20-bit shifter output.
        sq.delete();
        s_start = 1'b1;
        @(negedge clk_i);
        s_start = 1'b0; s_valid = 1'b1; s_data = AW2'(14'h3FFF);
        repeat (NB) @(negedge clk_i);
        s_valid = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("sat_nwrites", 64'(sq.size()), 64'(NB));
        for (int k = 0; k < int'(NB) && k < sq.size(); k++)
            chk($sformatf("sat_wr%0d", k), 64'(sq[k]), 64'(ref_shift(64'h3FFF, k)));
        if (sq.size() == NB) begin
`ifdef SHIFT_SAT_EN
            chk("sat_last", 64'(sq[NB-1]), 64'hFFFFF);
`else
            chk("sat_last", 64'(sq[NB-1]), 64'hFFF80);
`endif
        end
        chk("sat_idle", 64'({s_busy, s_adc_ready, s_rd, s_rv, s_wr}), 64'd0);
        chk("sat_res", 64'(s_res), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
